regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NREQ writeback sources (in-order pipe, load unit, mul/div).

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared defaults and index helpers for the writeback arbiter
package regfile_wb_arbiter_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int DW_DEFAULT = 32;
  localparam int REG_ZERO   = 0;

  // Explicit wrap so non-power-of-two requester counts stay in range.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin grant over NREQ requesters
module regfile_wb_arbiter_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant
);

  logic [PW-1:0] ptr_q, ptr_d;
  int            idx_c;
  logic          found_c;

  // Search starts at ptr and walks upward; the winner's successor becomes the new ptr.
  always_comb begin
    grant   = '0;
    ptr_d   = ptr_q;
    found_c = 1'b0;
    idx_c   = int'(ptr_q);
    for (int k = 0; k < NREQ; k++) begin
      if (!found_c && req_valid[idx_c]) begin
        grant[idx_c] = 1'b1;
        found_c      = 1'b1;
        ptr_d        = PW'(next_idx(idx_c, NREQ));
      end
      idx_c = next_idx(idx_c, NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port and tracks busy destinations
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  input  logic [AW-1:0]      rs_a,
  input  logic [AW-1:0]      rs_b,
  output logic               hazard_a,
  output logic               hazard_b,
  output logic               RegWEn,
  output logic [AW-1:0]      regD,
  output logic [DW-1:0]      wb_data
);

  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] grant;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            wen_q, wen_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NREG-1:0] busy_q, busy_d;

  regfile_wb_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready = reset ? '0 : grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // A granted write to x0 still completes the handshake but never raises the enable.
  always_comb begin
    wen_d  = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (|grant) begin
      wen_d  = (sel_rd != AW'(REG_ZERO));
      rd_d   = sel_rd;
      data_d = sel_data;
    end
  end

  // Clear on the edge the register file is written; a same-edge issue to that index wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q && rd_q != AW'(REG_ZERO)) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_valid && issue_rd != AW'(REG_ZERO)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign hazard_a = busy_q[rs_a];
  assign hazard_b = busy_q[rs_b];
  assign RegWEn   = wen_q;
  assign regD     = rd_q;
  assign wb_data  = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized checks against a behavioural model
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               issue_valid;
  logic [AW-1:0]      issue_rd;
  logic [AW-1:0]      rs_a;
  logic [AW-1:0]      rs_b;
  logic               hazard_a;
  logic               hazard_b;
  logic               RegWEn;
  logic [AW-1:0]      regD;
  logic [DW-1:0]      wb_data;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .RegWEn      (RegWEn),
    .regD        (regD),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_busy [32];
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]          = v;
    req_rd[i*AW +: AW]    = rd;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_wen  = 0;
    m_rd   = '0;
    m_data = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
  endtask

  // One clock: inputs already driven at posedge+1; check comb outputs, then registered outputs.
  task automatic cycle();
    logic [2:0] exp_ready;
    logic [4:0] g_rd;
    #2;
    m_grant = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (m_grant < 0 && req_valid[idx]) m_grant = idx;
    end
    exp_ready = (reset || m_grant < 0) ? 3'b000 : 3'(1 << m_grant);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("hazard_a", 32'(hazard_a), 32'(m_busy[rs_a]));
    chk("hazard_b", 32'(hazard_b), 32'(m_busy[rs_b]));
    @(posedge clk);
    if (reset) begin
      model_reset();
      m_grant = -1;
    end else begin
      if (m_wen && m_rd != 0) m_busy[m_rd] = 0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
      if (m_grant >= 0) begin
        g_rd   = req_rd[m_grant*AW +: AW];
        m_wen  = (g_rd != 0);
        m_rd   = g_rd;
        m_data = req_data[m_grant*DW +: DW];
        m_ptr  = (m_grant + 1) % NREQ;
      end else begin
        m_wen = 0;
      end
    end
    #1;
    chk("RegWEn", 32'(RegWEn), 32'(m_wen));
    if (m_wen) begin
      chk("regD", 32'(regD), 32'(m_rd));
      chk("wb_data", wb_data, m_data);
    end
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs_a        = '0;
    rs_b        = '0;
  endtask

  initial begin
    model_reset();
    idle_inputs();

    // 1: reset with every requester valid
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) cycle();
    chk("reset_RegWEn", 32'(RegWEn), 32'd0);
    chk("reset_regD", 32'(regD), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_hazard_a", 32'(hazard_a), 32'd0);

    // 2: continuous contention rotates 0,1,2,0,1,2
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(3 * c + i + 1), 32'hA000_0000 + 32'(16 * c + i));
      cycle();
      chk("contention_order", 32'(m_grant), 32'(c % NREQ));
      if (c > 0) chk("contention_wen", 32'(RegWEn), 32'd1);
    end

    // 3: granted write to x0 completes but does not write
    idle_inputs();
    set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle();
    chk("zero_dest_grant", 32'(m_grant), 32'd1);
    chk("zero_dest_wen", 32'(RegWEn), 32'd0);
    idle_inputs();
    cycle();

    // 4: scoreboard set by issue, cleared by the writeback
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs_a        = 5'd7;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("sb_hazard_set", 32'(hazard_a), 32'd1);
    set_req(0, 1'b1, 5'd7, 32'h1234_5678);
    cycle();
    chk("sb_write_out", 32'({RegWEn, regD}), 32'({1'b1, 5'd7}));
    chk("sb_write_data", wb_data, 32'h1234_5678);
    set_req(0, 1'b0, 5'd0, 32'd0);
    cycle();
    chk("sb_hazard_clear", 32'(hazard_a), 32'd0);

    // 5: set and clear of the same index on one edge keeps it busy
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    rs_a        = 5'd9;
    rs_b        = 5'd0;
    cycle();
    issue_valid = 1'b0;
    set_req(2, 1'b1, 5'd9, 32'h0000_0909);
    cycle();
    set_req(2, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("collision_hazard", 32'(hazard_a), 32'd1);
    chk("x0_no_hazard", 32'(hazard_b), 32'd0);

    // 6: reset asserted in a grant cycle
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(20 + i), 32'hC0DE_0000 + 32'(i));
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    rs_a        = 5'd12;
    cycle();
    issue_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    chk("midreset_wen", 32'(RegWEn), 32'd0);
    chk("midreset_busy", 32'(hazard_a), 32'd0);
    reset = 1'b0;
    cycle();
    chk("midreset_ptr", 32'(m_grant), 32'd0);

    // Randomized traffic with hold-while-waiting requesters
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && m_grant != i) || reset) begin
          set_req(i, 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom);
        end
      end
      issue_valid = 1'($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 15));
      rs_a        = 5'($urandom_range(0, 15));
      rs_b        = 5'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
